// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared float16 field layout and converter FSM states
// Purpose: constants, float word layout and FSM state enum shared by the
//          packer and unfloater blocks.
// Contents: EXP_W, MAN_W, EXP_BIAS, EXP_SPECIAL, float16_t, state_t.
package float_pkg;

   localparam int          EXP_W       = 8;
   localparam int          MAN_W       = 7;
   localparam int          EXP_BIAS    = 127;
   localparam logic [7:0]  EXP_SPECIAL = 8'hFF;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } float16_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ALIGN,
      S_DIGIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/unfloater_if.sv
// rtl/unfloater_if.sv - input/output handshake bundle of the unfloater
// Purpose: groups the float input handshake and the result handshake.
// Ports:   in_valid/in_ready/in_data (float word in),
//          out_valid/out_ready/out_sign/out_int/out_frac/out_ovf/out_special.
// Modports: slave = converter view, master = producer/consumer view.
interface unfloater_if #(
   parameter int DIGITS = 2
);
   logic                  in_valid;
   logic                  in_ready;
   logic [15:0]           in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_sign;
   logic [7:0]            out_int;
   logic [4*DIGITS-1:0]   out_frac;
   logic                  out_ovf;
   logic                  out_special;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sign, out_int, out_frac, out_ovf, out_special
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sign, out_int, out_frac, out_ovf, out_special
   );
endinterface

// File: rtl/frac_bcd_step.sv
// rtl/frac_bcd_step.sv - one decimal digit from a binary fraction
// Purpose: combinational multiply-by-10 of a binary fraction; the integer
//          part of the product is the next BCD digit (always <= 9).
// Ports:   frac (in, FRAC_W), digit (out, 4), frac_next (out, FRAC_W).
module frac_bcd_step #(
   parameter int FRAC_W = 16
) (
   input  logic [FRAC_W-1:0] frac,
   output logic [3:0]        digit,
   output logic [FRAC_W-1:0] frac_next
);
   logic [FRAC_W+3:0] t;

   // frac*10 = frac*8 + frac*2
   assign t         = {1'b0, frac, 3'b000} + {3'b000, frac, 1'b0};
   assign digit     = t[FRAC_W+3:FRAC_W];
   assign frac_next = t[FRAC_W-1:0];
endmodule

// File: rtl/unfloater.sv
// rtl/unfloater.sv - serial float16 to integer plus BCD fraction converter
// Purpose: converts {sign, exp[7:0], man[6:0]} into an 8-bit truncated
//          integer part and DIGITS truncated BCD fraction digits, one shift
//          per cycle during alignment and one digit per cycle afterwards.
// Ports:   clk, reset (async, active high), io (unfloater_if.slave).
// Config:  UNFLOATER_SATURATE_EN - overflow reports int=0xFF and all-9 digits
//          instead of zeros.
module unfloater
   import float_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int FRAC_W = 16
) (
   input  logic       clk,
   input  logic       reset,
   unfloater_if.slave io
);
   localparam int                 R_W     = 8 + FRAC_W;
   localparam int                 P_MIN_I = -FRAC_W;
   localparam logic signed [9:0]  P_MIN   = P_MIN_I[9:0];

   float16_t            w;
   state_t              state;
   logic [R_W-1:0]      r;
   logic [R_W-1:0]      r_load;
   logic [R_W-1:0]      r_next;
   logic [4:0]          cnt;
   logic                left;
   logic [FRAC_W-1:0]   f;
   logic [FRAC_W-1:0]   f_next;
   logic [3:0]          digit;
   logic [4*DIGITS-1:0] digit_ext;
   logic [2:0]          dcnt;
   logic signed [9:0]   p;
   logic [4:0]          p_abs;

   assign w         = io.in_data;
   assign p         = $signed({2'b00, w.exp}) - $signed(10'(EXP_BIAS));
   assign p_abs     = p[9] ? 5'(-p) : 5'(p);
   assign digit_ext = (4*DIGITS)'(digit);
   assign r_next    = left ? (r << 1) : (r >> 1);

   // Hidden one sits at the binary point, mantissa directly below it.
   always_comb begin
      r_load                      = '0;
      r_load[FRAC_W]              = 1'b1;
      r_load[FRAC_W-1 -: MAN_W]   = w.man;
   end

   frac_bcd_step #(.FRAC_W(FRAC_W)) u_step (
      .frac      (f),
      .digit     (digit),
      .frac_next (f_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         r              <= '0;
         cnt            <= '0;
         left           <= 1'b0;
         f              <= '0;
         dcnt           <= '0;
         io.in_ready    <= 1'b1;
         io.out_valid   <= 1'b0;
         io.out_sign    <= 1'b0;
         io.out_int     <= '0;
         io.out_frac    <= '0;
         io.out_ovf     <= 1'b0;
         io.out_special <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (io.in_valid) begin
                  io.in_ready    <= 1'b0;
                  io.out_sign    <= w.sign;
                  io.out_int     <= '0;
                  io.out_frac    <= '0;
                  io.out_ovf     <= 1'b0;
                  io.out_special <= 1'b0;
                  r              <= '0;
                  f              <= '0;
                  dcnt           <= '0;
                  if (w.exp == '0) begin
                     state        <= S_DONE;
                     io.out_valid <= 1'b1;
                  end else if (w.exp == EXP_SPECIAL) begin
                     io.out_special <= 1'b1;
                     state          <= S_DONE;
                     io.out_valid   <= 1'b1;
                  end else if (p >= 10'sd8) begin
                     io.out_ovf <= 1'b1;
`ifdef UNFLOATER_SATURATE_EN
                     io.out_int  <= 8'hFF;
                     io.out_frac <= {DIGITS{4'h9}};
`endif
                     state        <= S_DONE;
                     io.out_valid <= 1'b1;
                  end else if (p < P_MIN) begin
                     state        <= S_DONE;
                     io.out_valid <= 1'b1;
                  end else if (p == 10'sd0) begin
                     // Already aligned: split the loaded word straight away.
                     io.out_int <= r_load[R_W-1:FRAC_W];
                     f          <= r_load[FRAC_W-1:0];
                     state      <= S_DIGIT;
                  end else begin
                     r     <= r_load;
                     cnt   <= p_abs;
                     left  <= ~p[9];
                     state <= S_ALIGN;
                  end
               end
            end

            S_ALIGN: begin
               r   <= r_next;
               cnt <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  io.out_int <= r_next[R_W-1:FRAC_W];
                  f          <= r_next[FRAC_W-1:0];
                  state      <= S_DIGIT;
               end
            end

            S_DIGIT: begin
               // Digits enter at the bottom and move up, so the first one ends
               // in the top nibble.
               io.out_frac <= (io.out_frac << 4) | digit_ext;
               f           <= f_next;
               dcnt        <= dcnt + 3'd1;
               if (dcnt == 3'(DIGITS-1)) begin
                  state        <= S_DONE;
                  io.out_valid <= 1'b1;
               end
            end

            S_DONE: begin
               if (io.out_ready) begin
                  io.out_valid <= 1'b0;
                  io.in_ready  <= 1'b1;
                  state        <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_unfloater.sv
// tb/tb_unfloater.sv - directed scoreboard bench for unfloater
module tb_unfloater;
   localparam int DIGITS = 2;
   localparam int FRAC_W = 16;

   typedef struct {
      logic        sign;
      logic [7:0]  ival;
      logic [7:0]  frac;
      logic        ovf;
      logic        special;
      int          lat;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   exp_t sb[$];

   unfloater_if #(.DIGITS(DIGITS)) bus ();

   unfloater #(.DIGITS(DIGITS), .FRAC_W(FRAC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Independent reference: value = 1.man * 2^p held as a FRAC_W fraction.
   function automatic exp_t model(input logic [15:0] wd);
      exp_t   e;
      int     ex;
      int     p;
      longint v;
      longint fr;
      longint mask;
      ex        = int'(wd[14:7]);
      p         = ex - 127;
      e.sign    = wd[15];
      e.ival    = 8'h00;
      e.frac    = 8'h00;
      e.ovf     = 1'b0;
      e.special = 1'b0;
      e.lat     = 1;
      mask      = (longint'(1) << FRAC_W) - 1;
      if (ex == 0) begin
      end else if (ex == 255) begin
         e.special = 1'b1;
      end else if (p >= 8) begin
         e.ovf = 1'b1;
`ifdef UNFLOATER_SATURATE_EN
         e.ival = 8'hFF;
         e.frac = 8'h99;
`endif
      end else if (p < -FRAC_W) begin
      end else begin
         v = longint'(128 + int'(wd[6:0])) << (FRAC_W - 7);
         if (p > 0) v = v << p;
         else v = v >> (-p);
         e.ival = 8'((v >> FRAC_W) & 255);
         fr = v & mask;
         for (int i = 0; i < DIGITS; i++) begin
            fr     = fr * 10;
            e.frac = {e.frac[3:0], 4'((fr >> FRAC_W) & 15)};
            fr     = fr & mask;
         end
         e.lat = 1 + ((p < 0) ? -p : p) + DIGITS;
      end
      return e;
   endfunction

   task automatic send(input logic [15:0] wd, input bit push);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = wd;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
      if (push) sb.push_back(model(wd));
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic recv(input int hold);
      exp_t e;
      int   lat;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e   = sb.pop_front();
         lat = 1;
         @(negedge clk);
         while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
         end
         chk("out_valid", 32'(bus.out_valid), 32'd1);
         chk("latency", 32'(lat), 32'(e.lat));
         chk("out_sign", 32'(bus.out_sign), 32'(e.sign));
         chk("out_int", 32'(bus.out_int), 32'(e.ival));
         chk("out_frac", 32'(bus.out_frac), 32'(e.frac));
         chk("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
         chk("out_special", 32'(bus.out_special), 32'(e.special));
         for (int i = 0; i < hold; i++) begin
            // an offered word during the hold must be ignored
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h4000;
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_int", 32'(bus.out_int), 32'(e.ival));
            chk("hold_frac", 32'(bus.out_frac), 32'(e.frac));
            chk("hold_sign", 32'(bus.out_sign), 32'(e.sign));
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("after_hs_valid", 32'(bus.out_valid), 32'd0);
         chk("after_hs_in_ready", 32'(bus.in_ready), 32'd1);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_outs"}, {22'd0, bus.out_sign, bus.out_int, bus.out_ovf},
          32'd0);
      chk({tag, "_frac_flags"}, {23'd0, bus.out_frac, bus.out_special}, 32'd0);
   endtask

   initial begin
      logic [15:0] extra [8];
      total         = 0;
      bad           = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0000;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      reset = 1'b0;
      @(negedge clk);

      send(16'h4120, 1'b1); recv(0);          // 10.0
      send(16'h3E80, 1'b1); recv(0);          // 0.25

      bus.out_ready = 1'b0;                   // -5.0 held 4 cycles
      send(16'hC0A0, 1'b1); recv(4);
      send(16'h3FC0, 1'b1); recv(0);          // 1.5

      send(16'h4380, 1'b1); recv(0);          // 256.0 overflow
      send(16'h7F80, 1'b1); recv(0);          // inf
      send(16'h8000, 1'b1); recv(0);          // -0

      extra[0] = 16'h437F;                    // 255.0, largest p
      extra[1] = 16'h3780;                    // 2^-16, smallest p kept
      extra[2] = 16'h3700;                    // 2^-17, underflow
      extra[3] = 16'h7FC0;                    // NaN
      extra[4] = 16'h3DCC;                    // ~0.0996
      extra[5] = 16'h42C8;                    // 100.0
      extra[6] = 16'h0040;                    // denormal
      extra[7] = 16'hBF99;                    // -1.195...
      for (int i = 0; i < 8; i++) begin
         send(extra[i], 1'b1);
         recv(0);
      end

      // reset while aligning 10.0
      send(16'h4120, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_state("mid_reset");
      reset = 1'b0;
      @(negedge clk);
      send(16'h3FC0, 1'b1); recv(0);

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/unfloater.md
Name: unfloater

Overview:
- Serial converter from the 16-bit float format (1 sign, 8 exponent bias 127, 7 mantissa) back to an 8-bit unsigned integer part plus decimal fraction digits (BCD).
- Inverse of the team's integer/decimal-to-float packer. Sits between float-producing datapath units and display/IO logic.
- Valid/ready handshakes on both sides. Multi-cycle: one shift per cycle, then one BCD digit per cycle.

Parameters:
- DIGITS, 2, number of BCD fraction digits produced (legal 1..4).
- FRAC_W, 16, internal binary fraction width after alignment (legal 8..16).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  float word available.
- in_ready  output  1  block can accept (high only in IDLE).
- in_data  input  16  {sign, exponent[7:0], mantissa[6:0]}.
- out_valid  output  1  result held stable until accepted.
- out_ready  input  1  consumer accepts result.
- out_sign  output  1  copy of input sign.
- out_int  output  8  integer part, truncated.
- out_frac  output  4*DIGITS  BCD fraction digits; most significant digit in the top nibble.
- out_ovf  output  1  |value| >= 256.
- out_special  output  1  exponent == 255 (inf/NaN).

Behaviour:
- Reset (async, any state, including mid-conversion): state IDLE; in_ready=1; out_valid=0; all data outputs and flags 0; internal registers cleared.
- FSM states: IDLE, ALIGN, DIGIT, DONE.
- IDLE: on in_valid&&in_ready, capture the word. Let e = exponent, p = e-127.
  - e==0: zero. Denormals are treated as zero. Go to DONE with int=0 and all digits 0.
  - e==255: out_special=1, int=0, digits 0. Go to DONE.
  - p>=8: out_ovf=1. Go to DONE. Data outputs per the optional feature.
  - p<-FRAC_W: zero result. Go to DONE.
  - Otherwise load the fixed-point register R[8+FRAC_W-1:0] with the binary point at FRAC_W: R[FRAC_W]=1, R[FRAC_W-1:FRAC_W-7]=mantissa, rest 0. Shift count = |p|.
    - Go to ALIGN if p!=0, else to DIGIT.
- ALIGN: one shift per cycle.
  - Shift left if p>0; shift logical right if p<0.
  - Bits shifted out below the LSB are discarded (truncation, no rounding).
  - After |p| cycles, out_int = R[8+FRAC_W-1:FRAC_W] and the fraction F = R[FRAC_W-1:0]. Go to DIGIT.
- DIGIT: one digit per cycle, for DIGITS cycles.
  - T = F*10, which is FRAC_W+4 bits wide.
  - The next BCD digit is T[FRAC_W+3:FRAC_W] (always <=9); F = T[FRAC_W-1:0].
  - Digits fill from the most significant nibble down (truncated decimal).
  - After DIGITS cycles, go to DONE.
- DONE: out_valid=1; outputs stable. On out_ready, go to IDLE the next cycle.
  - in_ready rises the cycle after the output handshake; there is no same-cycle back-to-back.
- Latency from the input-accept edge to out_valid high:
  - Normal path: 1 + |p| + DIGITS cycles.
  - zero/special/ovf/underflow paths: 1 cycle.
- out_valid is held indefinitely while out_ready=0.
- in_valid is ignored outside IDLE.
- Flags and data clear when the next input is accepted.
- out_sign is reported for every case, including zero (-0 gives sign 1) and special.

Optional Feature:
- Macro: UNFLOATER_SATURATE_EN.
- Defined: on overflow, out_int=8'hFF and every BCD digit = 4'h9; out_ovf=1.
- Undefined: on overflow, out_int=0 and digits 0; out_ovf=1.
- Latency is the same in both builds.

Decomposition:
- Shared package float_pkg holds:
  - EXP_W=8, MAN_W=7, EXP_BIAS=127, EXP_SPECIAL=8'hFF.
  - A field-extract typedef for the 16-bit float word.
  - The FSM state enum.
- The packer block uses the same package.
- One sub-module, frac_bcd_step: combinational multiply-by-10 giving {digit, next fraction}. Instantiated once and reused each DIGIT cycle.

Test Plan:
- 0x4120 (10.0), out_ready=1 -> out_int=10, out_frac=0x00, sign 0, flags 0; out_valid at 1+3+2=6 cycles after accept.
- 0x3E80 (0.25) -> out_int=0, out_frac=0x25; latency 1+2+2=5.
- 0xC0A0 (-5.0) then 0x3FC0 (1.5), with out_ready held low 4 cycles on the first -> first result sign=1, int=5, held stable; in_ready stays low until the handshake. Second result int=1, frac=0x50.
- 0x4380 (256.0) -> out_ovf=1, 1-cycle latency; int/digits 0 without the macro, 0xFF/0x99 with UNFLOATER_SATURATE_EN.
- 0x7F80 (inf) -> out_special=1, int 0; 0x8000 -> sign=1, int=0, frac=0x00.
- Assert reset during ALIGN of 0x4120 -> next cycle in_ready=1, out_valid=0, outputs 0; a new 0x3FC0 then converts correctly.
